// File: rtl/arp_announce.sv
// Gratuitous ARP announcer: emits a 60-byte ARP frame as an 8-bit stream.
// Ports:
//   clk, sys_rst         : clock, asynchronous active-high reset
//   if_v4addr, if_macaddr: interface IPv4 / MAC address
//   start                : one-cycle request for one frame
//   tx_tready            : downstream accepts the current byte
//   tx_tdata/tvalid/tlast: frame byte stream out
//   busy                 : frame in flight
//   sent_count           : completed frames, wraps at 16 bits
// Frames are also requested by the periodic timer (PERIOD_CYCLES > 0)
// and by any change of the address inputs.
module arp_announce #(
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [31:0] if_v4addr,
    input  logic [47:0] if_macaddr,
    input  logic        start,
    input  logic        tx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    output logic        busy,
    output logic [15:0] sent_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state;
    logic [5:0]  idx;
    logic        pending;
    logic        prime;
    logic [31:0] tmr;
    logic [31:0] sh_ip;
    logic [47:0] sh_mac;
    logic [31:0] snap_ip;
    logic [47:0] snap_mac;

    logic timer_ev;
    logic chg_ev;
    logic trig;
    logic fire;

    // Byte i of the frame built from a given address pair.
    function automatic logic [7:0] frame_byte(
        input logic [5:0]  i,
        input logic [31:0] ip,
        input logic [47:0] mac
    );
        logic [7:0] b;
        int         k;
        b = 8'h00;
        k = int'(i);
        case (i) inside
            [6'd0:6'd5]:   b = 8'hFF;
            [6'd6:6'd11]:  b = mac[8*(11-k) +: 8];
            6'd12:         b = 8'h08;
            6'd13:         b = 8'h06;
            6'd14:         b = 8'h00;
            6'd15:         b = 8'h01;
            6'd16:         b = 8'h08;
            6'd17:         b = 8'h00;
            6'd18:         b = 8'h06;
            6'd19:         b = 8'h04;
            6'd20:         b = 8'h00;
            6'd21:         b = 8'h01;
            [6'd22:6'd27]: b = mac[8*(27-k) +: 8];
            [6'd28:6'd31]: b = ip[8*(31-k) +: 8];
            [6'd38:6'd41]: b = ip[8*(41-k) +: 8];
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

    assign timer_ev = (PERIOD_CYCLES != 0) &&
                      (tmr == PERIOD_CYCLES - 32'd1);

    // The first cycle after reset compares against zeroed shadows,
    // so prime masks that spurious mismatch.
    assign chg_ev = !prime &&
                    ((if_v4addr != sh_ip) ||
                     (if_macaddr != sh_mac));

    assign trig = start || timer_ev || chg_ev;
    assign fire = tx_tvalid && tx_tready;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            idx        <= 6'd0;
            pending    <= 1'b0;
            prime      <= 1'b1;
            tmr        <= 32'd0;
            sh_ip      <= 32'd0;
            sh_mac     <= 48'd0;
            snap_ip    <= 32'd0;
            snap_mac   <= 48'd0;
            tx_tdata   <= 8'h00;
            tx_tvalid  <= 1'b0;
            tx_tlast   <= 1'b0;
            busy       <= 1'b0;
            sent_count <= 16'd0;
        end else begin
            prime  <= 1'b0;
            sh_ip  <= if_v4addr;
            sh_mac <= if_macaddr;

            if (PERIOD_CYCLES != 0) begin
                tmr <= timer_ev ? 32'd0 : tmr + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    if (trig || pending) begin
                        state     <= SEND;
                        busy      <= 1'b1;
                        tx_tvalid <= 1'b1;
                        idx       <= 6'd0;
                        tx_tdata  <= 8'hFF;
                        tx_tlast  <= 1'b0;
                        pending   <= 1'b0;
                        snap_ip   <= if_v4addr;
                        snap_mac  <= if_macaddr;
                    end
                end
                SEND: begin
                    // Any number of requests during a frame fold
                    // into a single follow-up frame.
                    if (trig) begin
                        pending <= 1'b1;
                    end
                    if (fire) begin
                        if (idx == 6'd59) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            tx_tvalid  <= 1'b0;
                            tx_tlast   <= 1'b0;
                            idx        <= 6'd0;
                            sent_count <= sent_count + 16'd1;
                        end else begin
                            idx      <= idx + 6'd1;
                            tx_tdata <= frame_byte(idx + 6'd1,
                                                   snap_ip,
                                                   snap_mac);
                            tx_tlast <= (idx == 6'd58);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_announce.sv
// Bench for arp_announce: randomized stimulus checked each cycle
// against a frame-table reference model, plus a timer instance.
module tb_arp_announce;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        start;
    logic        tready;
    logic [7:0]  tdata;
    logic        tvalid, tlast, busy;
    logic [15:0] cnt;

    logic [31:0] ip1 = 32'hC0A80001;
    logic [47:0] mac1 = 48'h0200_0000_0042;
    logic        start1 = 1'b0;
    logic        tready1 = 1'b1;
    logic [7:0]  tdata1;
    logic        tvalid1, tlast1, busy1;
    logic [15:0] cnt1;

    arp_announce #(.PERIOD_CYCLES(0)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .if_v4addr(ip), .if_macaddr(mac),
        .start(start), .tx_tready(tready),
        .tx_tdata(tdata), .tx_tvalid(tvalid),
        .tx_tlast(tlast), .busy(busy),
        .sent_count(cnt)
    );

    arp_announce #(.PERIOD_CYCLES(200)) dut_t (
        .clk(clk), .sys_rst(sys_rst),
        .if_v4addr(ip1), .if_macaddr(mac1),
        .start(start1), .tx_tready(tready1),
        .tx_tdata(tdata1), .tx_tvalid(tvalid1),
        .tx_tlast(tlast1), .busy(busy1),
        .sent_count(cnt1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0]  m_frame[60];
    bit          m_busy, m_pend, m_prime;
    int          m_idx;
    logic [15:0] m_cnt;
    logic [31:0] m_sip;
    logic [47:0] m_smac;

    task automatic build(input logic [31:0] a,
                         input logic [47:0] b);
        for (int i = 0; i < 60; i++) m_frame[i] = 8'h00;
        for (int i = 0; i < 6; i++) m_frame[i] = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            m_frame[6+k]  = b[47-8*k -: 8];
            m_frame[22+k] = b[47-8*k -: 8];
        end
        m_frame[12] = 8'h08; m_frame[13] = 8'h06;
        m_frame[14] = 8'h00; m_frame[15] = 8'h01;
        m_frame[16] = 8'h08; m_frame[17] = 8'h00;
        m_frame[18] = 8'h06; m_frame[19] = 8'h04;
        m_frame[20] = 8'h00; m_frame[21] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            m_frame[28+k] = a[31-8*k -: 8];
            m_frame[38+k] = a[31-8*k -: 8];
        end
    endtask

    logic [7:0] log_b[$];
    bit         log_l[$];
    int         n1;

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) n1 <= 0;
        else         n1 <= n1 + 1;
    end

    initial begin : compare
        bit         chg, trig, stall;
        logic [7:0] pd;
        logic       pl;
        stall = 0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                m_busy = 0; m_pend = 0; m_prime = 1;
                m_idx = 0; m_cnt = 0;
                m_sip = 0; m_smac = 0;
                stall = 0;
                check("rst_valid", tvalid, 0);
                check("rst_last", tlast, 0);
                check("rst_data", tdata, 0);
                check("rst_busy", busy, 0);
                check("rst_cnt", cnt, 0);
            end else begin
                check("valid", tvalid, m_busy);
                check("busy", busy, m_busy);
                check("last", tlast, m_busy && m_idx == 59);
                check("cnt", cnt, m_cnt);
                if (m_busy) check("data", tdata, m_frame[m_idx]);
                if (stall && tvalid)
                    check("stall_hold", {tdata, tlast}, {pd, pl});
                stall = tvalid && !tready;
                pd = tdata;
                pl = tlast;
                if (tvalid && tready) begin
                    log_b.push_back(tdata);
                    log_l.push_back(tlast);
                end
                chg = !m_prime &&
                      (ip != m_sip || mac != m_smac);
                trig = start || chg;
                if (!m_busy) begin
                    if (trig || m_pend) begin
                        build(ip, mac);
                        m_busy = 1; m_idx = 0; m_pend = 0;
                    end
                end else begin
                    if (trig) m_pend = 1;
                    if (tready) begin
                        if (m_idx == 59) begin
                            m_busy = 0;
                            m_cnt++;
                        end else m_idx++;
                    end
                end
                m_sip = ip; m_smac = mac; m_prime = 0;
            end
            check("tmr_valid", tvalid1,
                  n1 >= 200 && n1 % 200 < 60);
            check("tmr_last", tlast1,
                  n1 >= 200 && n1 % 200 == 59);
            check("tmr_cnt", cnt1,
                  n1 >= 60 ? (n1 - 60) / 200 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] t,
                            input int budget,
                            input string name);
        int i = 0;
        while (cnt !== t && i < budget) begin
            tick();
            i++;
        end
        check(name, cnt, t);
    endtask

    logic [7:0] golden[$];
    logic [7:0] e_mac1[6] = '{8'h00, 8'h37, 8'h76, 8'h00, 8'h00, 8'h01};
    logic [7:0] e_mac2[6] = '{8'h00, 8'h37, 8'h76, 8'h00, 8'h00, 8'h02};
    logic [7:0] e_ip1[4]  = '{8'h0A, 8'h00, 8'h15, 8'hC7};
    logic [7:0] e_ip2[4]  = '{8'h0A, 8'h00, 8'h15, 8'hC8};

    initial begin : stim
        int s, i, saw, diff;
        ip = 32'h0A0015C7;
        mac = 48'h0037_7600_0001;
        start = 0;
        tready = 1;
        repeat (3) tick();
        sys_rst = 0;
        repeat (6) tick();
        check("t0_no_frame", tvalid, 0);

        // Basic frame
        log_b.delete(); log_l.delete();
        pulse_start();
        check("t1_latency", tvalid, 1);
        wait_cnt(1, 100, "t1_cnt");
        tick();
        check("t1_len", log_b.size(), 60);
        if (log_b.size() == 60) begin
            for (int k = 0; k < 6; k++)
                check("t1_mac", log_b[6+k], e_mac1[k]);
            for (int k = 0; k < 4; k++)
                check("t1_ip", log_b[28+k], e_ip1[k]);
            s = 0;
            foreach (log_l[k]) s += int'(log_l[k]);
            check("t1_tlast_n", s, 1);
            check("t1_tlast_pos", log_l[59], 1);
            check("t1_b12", log_b[12], 8'h08);
            check("t1_b19", log_b[19], 8'h04);
        end
        golden = log_b;

        // Backpressure
        log_b.delete(); log_l.delete();
        pulse_start();
        i = 0;
        while (cnt !== 16'd2 && i < 1000) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        tready = 1;
        check("t2_cnt", cnt, 2);
        tick();
        check("t2_len", log_b.size(), 60);
        diff = 0;
        if (log_b.size() == 60)
            foreach (golden[k]) if (log_b[k] !== golden[k]) diff++;
        check("t2_same_bytes", diff, 0);

        // Collapse
        log_b.delete(); log_l.delete();
        pulse_start();
        repeat (10) tick();
        pulse_start();
        ip = 32'h0A0015C8;
        tick();
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_cnt(4, 300, "t3_cnt");
        repeat (100) tick();
        check("t3_cnt_final", cnt, 4);
        check("t3_len", log_b.size(), 120);
        if (log_b.size() == 120) begin
            for (int k = 0; k < 4; k++) begin
                check("t3_ip_old", log_b[28+k], e_ip1[k]);
                check("t3_ip_new", log_b[88+k], e_ip2[k]);
            end
        end

        // Change detect
        log_b.delete(); log_l.delete();
        mac = 48'h0037_7600_0002;
        wait_cnt(5, 100, "t4_cnt");
        repeat (80) tick();
        check("t4_cnt_final", cnt, 5);
        if (log_b.size() == 60)
            for (int k = 0; k < 6; k++)
                check("t4_mac", log_b[22+k], e_mac2[k]);
        else
            check("t4_len", log_b.size(), 60);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 19) == 0);
            tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) ip = $urandom;
            if ($urandom_range(0, 149) == 0)
                mac = {16'h0037, 32'($urandom)};
            tick();
        end
        start = 0;
        tready = 1;
        repeat (150) tick();
        check("t5_idle", tvalid, 0);

        // Reset mid-frame
        log_b.delete(); log_l.delete();
        pulse_start();
        i = 0;
        while (log_b.size() < 30 && i < 100) begin
            tick();
            i++;
        end
        check("t6_reached30", log_b.size(), 30);
        sys_rst = 1;
        #2;
        check("t6_abort_valid", tvalid, 0);
        check("t6_abort_cnt", cnt, 0);
        check("t6_abort_last", tlast, 0);
        s = 0;
        foreach (log_l[k]) s += int'(log_l[k]);
        check("t6_no_tlast", s, 0);
        repeat (3) tick();
        sys_rst = 0;
        saw = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tvalid) saw++;
        end
        check("t6_no_restart", saw, 0);

        // Let the timer instance produce two frames
        repeat (460) tick();
        check("t7_tmr_frames", cnt1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
